// File: rtl/avmm_triple_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : avmm_triple_pkg
//  Description : Shared types and helpers for the Avalon-MM "triple" host.
//  Revision    : 1.0 - initial release
// ============================================================================
package avmm_triple_pkg;

    // Width of the Avalon-MM address bus
    localparam int ADDR_W = 8;

    // Working width of expected_triple; callers truncate to their data width
    // (data widths up to 64 bits are supported)
    localparam int TRIPLE_W = 64;

    // Host transaction sequencer states
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WRITE = 3'd1,
        READ  = 3'd2,
        WAIT  = 3'd3,
        RESP  = 3'd4
    } host_state_t;

    // Reference value the agent should return: 3*x, wrapping silently
    function automatic logic [TRIPLE_W-1:0] expected_triple(input logic [TRIPLE_W-1:0] x);
        return (x << 1) + x;
    endfunction

endpackage
`default_nettype wire

// File: rtl/avmm_triple_host.sv
`default_nettype none
// ============================================================================
//  Module      : avmm_triple_host
//  Description : Avalon-MM host that writes an operand to the "triple" agent,
//                reads the result back after a fixed latency, returns it on a
//                result stream and self-checks it against 3*operand.
//  Revision    : 1.0 - initial release
// ============================================================================
module avmm_triple_host
    import avmm_triple_pkg::*;
#(
    parameter int                N            = 32,
    parameter logic [ADDR_W-1:0] ADDR         = 8'h00,
    parameter int                READ_LATENCY = 1,
    parameter int                CNT_W        = 16
) (
    input  logic              csi_clk,
    input  logic              rsi_srst,
    // operand command stream
    input  logic              asi_cmd_valid,
    output logic              asi_cmd_ready,
    input  logic [N-1:0]      asi_cmd_data,
    // Avalon-MM host port
    output logic [ADDR_W-1:0] avm_m0_address,
    output logic              avm_m0_write,
    output logic [N-1:0]      avm_m0_writedata,
    output logic              avm_m0_read,
    input  logic [N-1:0]      avm_m0_readdata,
    input  logic              avm_m0_waitrequest,
    // result stream
    output logic              aso_res_valid,
    input  logic              aso_res_ready,
    output logic [N-1:0]      aso_res_data,
    output logic              aso_res_err,
    // status counters
    output logic [CNT_W-1:0]  sts_done_cnt,
    output logic [CNT_W-1:0]  sts_err_cnt
);

    // Latency counter only has to hold READ_LATENCY-1
    localparam int               LAT_W      = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
    localparam logic [LAT_W-1:0] c_LAT_INIT = LAT_W'(READ_LATENCY - 1);
    localparam logic [CNT_W-1:0] c_CNT_MAX  = '1;

    host_state_t      r_state;
    host_state_t      w_state_nxt;
    logic [N-1:0]     r_op;
    logic [LAT_W-1:0] r_lat_cnt;
    logic [N-1:0]     r_res_data;
    logic             r_res_err;
    logic [CNT_W-1:0] r_done_cnt;
    logic [CNT_W-1:0] r_err_cnt;

    logic [N-1:0]     w_expected;
    logic             w_cmd_acc;
    logic             w_rd_acc;
    logic             w_capture;
    logic             w_res_acc;

    assign w_expected = N'(expected_triple(TRIPLE_W'(r_op)));
    assign w_cmd_acc  = (r_state == IDLE) && asi_cmd_valid;
    assign w_rd_acc   = (r_state == READ) && !avm_m0_waitrequest;
    assign w_capture  = (r_state == WAIT) && (r_lat_cnt == '0);
    assign w_res_acc  = (r_state == RESP) && aso_res_ready;

    // State register
    always_ff @(posedge csi_clk) begin
        if (rsi_srst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; bus/stream outputs decode from registered state only
    always_comb begin
        w_state_nxt      = r_state;
        asi_cmd_ready    = 1'b0;
        avm_m0_address   = '0;
        avm_m0_write     = 1'b0;
        avm_m0_writedata = '0;
        avm_m0_read      = 1'b0;
        aso_res_valid    = 1'b0;
        case (r_state)
            IDLE: begin
                asi_cmd_ready = 1'b1;
                if (asi_cmd_valid) begin
                    w_state_nxt = WRITE;
                end
            end
            WRITE: begin
                avm_m0_write     = 1'b1;
                avm_m0_address   = ADDR;
                avm_m0_writedata = r_op;
                if (!avm_m0_waitrequest) begin
                    w_state_nxt = READ;
                end
            end
            READ: begin
                avm_m0_read    = 1'b1;
                avm_m0_address = ADDR;
                if (!avm_m0_waitrequest) begin
                    w_state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (r_lat_cnt == '0) begin
                    w_state_nxt = RESP;
                end
            end
            RESP: begin
                aso_res_valid = 1'b1;
                if (aso_res_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Operand latch, read-latency countdown and result capture/check
    always_ff @(posedge csi_clk) begin
        if (rsi_srst) begin
            r_op       <= '0;
            r_lat_cnt  <= '0;
            r_res_data <= '0;
            r_res_err  <= 1'b0;
        end else begin
            if (w_cmd_acc) begin
                r_op <= asi_cmd_data;
            end
            if (w_rd_acc) begin
                r_lat_cnt <= c_LAT_INIT;
            end else if ((r_state == WAIT) && (r_lat_cnt != '0)) begin
                r_lat_cnt <= r_lat_cnt - 1'b1;
            end
            if (w_capture) begin
                r_res_data <= avm_m0_readdata;
                r_res_err  <= (avm_m0_readdata != w_expected);
            end
        end
    end

    // Saturating done/error counters, bumped on the result handshake
    always_ff @(posedge csi_clk) begin
        if (rsi_srst) begin
            r_done_cnt <= '0;
            r_err_cnt  <= '0;
        end else if (w_res_acc) begin
            if (r_done_cnt != c_CNT_MAX) begin
                r_done_cnt <= r_done_cnt + 1'b1;
            end
            if (r_res_err && (r_err_cnt != c_CNT_MAX)) begin
                r_err_cnt <= r_err_cnt + 1'b1;
            end
        end
    end

    assign aso_res_data = r_res_data;
    assign aso_res_err  = r_res_err;
    assign sts_done_cnt = r_done_cnt;
    assign sts_err_cnt  = r_err_cnt;

endmodule
`default_nettype wire
